// File: rtl/priority_pkg.sv
// Shared definitions for the priority encoder/decoder pair: state encoding,
// the index-to-one-hot decode map and counter width.
package priority_pkg;

    localparam int unsigned PDEC_CNT_W = 4;
    localparam int unsigned PDEC_IDX_W = 2;
    localparam int unsigned PDEC_VEC_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        DRIVE = 1'b1
    } pdec_state_e;

    // Index 0 is the highest-priority request (MSB), matching the encoder.
    function automatic logic [PDEC_VEC_W-1:0] pdec_decode(input logic [PDEC_IDX_W-1:0] idx);
        logic [PDEC_VEC_W-1:0] vec;
        case (idx)
            2'd0:    vec = 4'b1000;
            2'd1:    vec = 4'b0100;
            2'd2:    vec = 4'b0010;
            default: vec = 4'b0001;
        endcase
        return vec;
    endfunction

endpackage

// File: rtl/priority_dec_pend.sv
// One-entry holding register for a code that arrives while another is being driven.
module priority_dec_pend
    import priority_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [PDEC_IDX_W-1:0] din,
    output logic [PDEC_IDX_W-1:0] dout,
    output logic                  full
);

    logic [PDEC_IDX_W-1:0] data_q;
    logic                  full_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            full_q <= 1'b0;
        end else begin
            if (push) begin
                data_q <= din;
            end
            full_q <= push | (full_q & ~pop);
        end
    end

    assign dout = data_q;
    assign full = full_q;

endmodule

// File: rtl/priority_dec.sv
// Registered index-to-one-hot decoder with programmable hold time and a one-entry
// pending buffer. Optional sticky history of driven vectors: PRIORITY_DEC_HIST_EN.
module priority_dec
    import priority_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PDEC_IDX_W-1:0] Y,
    input  logic                  valid,
    output logic                  ready,
    output logic [PDEC_VEC_W-1:0] D,
    output logic                  D_valid
`ifdef PRIORITY_DEC_HIST_EN
    ,
    output logic [PDEC_VEC_W-1:0] hist,
    input  logic                  hist_clr
`endif
);

    localparam logic [PDEC_CNT_W-1:0] HOLD_LD = PDEC_CNT_W'(HOLD_CYCLES - 1);

    pdec_state_e           state_q, state_d;
    logic [PDEC_CNT_W-1:0] cnt_q, cnt_d;
    logic [PDEC_VEC_W-1:0] d_q, d_d;
    logic                  pend_push, pend_pop, pend_full;
    logic [PDEC_IDX_W-1:0] pend_y;
    logic                  accept;

    assign ready  = ~pend_full & ~rst;
    assign accept = valid & ready;

    priority_dec_pend u_pend (
        .clk  (clk),
        .rst  (rst),
        .push (pend_push),
        .pop  (pend_pop),
        .din  (Y),
        .dout (pend_y),
        .full (pend_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            d_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            d_q     <= d_d;
        end
    end

    // Next state: the pending code takes precedence over a fresh code at end of hold.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        d_d       = d_q;
        pend_push = 1'b0;
        pend_pop  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = DRIVE;
                    d_d     = pdec_decode(Y);
                    cnt_d   = HOLD_LD;
                end
            end
            DRIVE: begin
                if (cnt_q != '0) begin
                    cnt_d     = cnt_q - PDEC_CNT_W'(1);
                    pend_push = accept;
                end else if (pend_full) begin
                    pend_pop = 1'b1;
                    d_d      = pdec_decode(pend_y);
                    cnt_d    = HOLD_LD;
                end else if (accept) begin
                    d_d   = pdec_decode(Y);
                    cnt_d = HOLD_LD;
                end else begin
                    state_d = IDLE;
                    d_d     = '0;
                end
            end
            default: begin
                state_d = IDLE;
                d_d     = '0;
            end
        endcase
    end

    assign D       = d_q;
    assign D_valid = (state_q == DRIVE);

`ifdef PRIORITY_DEC_HIST_EN
    logic [PDEC_VEC_W-1:0] hist_q;

    always_ff @(posedge clk) begin
        if (rst || hist_clr) begin
            hist_q <= '0;
        end else begin
            hist_q <= hist_q | d_q;
        end
    end

    assign hist = hist_q;
`endif

endmodule
